// File: rtl/ahb_lite_slv_sif.sv
// ---------------------------------------------------------------------------
// ahb_lite_slv_sif
//
// AHB-Lite subordinate that turns single AHB-Lite transfers into a simple
// one-request-at-a-time client handshake for a register block. It selects the
// client-sized lane out of the wide AHB data bus and produces the two-cycle
// AHB ERROR response. The error can come from a bad transfer (oversized or
// misaligned) or from the client's err input.
//
// Parameters
//   AHB_ADDR_WIDTH    : AHB byte address width (10..64)
//   AHB_DATA_WIDTH    : AHB data bus width (32/64/128/256)
//   CLIENT_DATA_WIDTH : client word width (power of two >= 8, <= AHB width)
//
// Ports
//   hclk, hreset_n            : clock, asynchronous active-low reset
//   haddr_i, hsize_i, htrans_i,
//   hwrite_i, hsel_i, hready_i: AHB address-phase inputs
//   hwdata_i                  : AHB write data (data phase)
//   hrdata_o                  : AHB read data, client word in its lane
//   hreadyout_o, hresp_o      : AHB transfer-complete and ERROR response
//   dv, write, addr, wdata    : client request valid, direction, byte
//                               address and write lane
//   hld, err, rdata           : client stall, client error, client read data
// ---------------------------------------------------------------------------
module ahb_lite_slv_sif #(
  parameter int AHB_ADDR_WIDTH    = 32,
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int CLIENT_DATA_WIDTH = 32
) (
  input  logic                         hclk,
  input  logic                         hreset_n,
  input  logic [AHB_ADDR_WIDTH-1:0]    haddr_i,
  input  logic [2:0]                   hsize_i,
  input  logic [1:0]                   htrans_i,
  input  logic                         hwrite_i,
  input  logic [AHB_DATA_WIDTH-1:0]    hwdata_i,
  input  logic                         hsel_i,
  input  logic                         hready_i,
  output logic [AHB_DATA_WIDTH-1:0]    hrdata_o,
  output logic                         hreadyout_o,
  output logic                         hresp_o,
  output logic                         dv,
  input  logic                         hld,
  input  logic                         err,
  output logic                         write,
  output logic [CLIENT_DATA_WIDTH-1:0] wdata,
  output logic [AHB_ADDR_WIDTH-1:0]    addr,
  input  logic [CLIENT_DATA_WIDTH-1:0] rdata
);

  // Byte-address bits that pick a client lane inside the AHB data bus.
  localparam int LSB    = $clog2(CLIENT_DATA_WIDTH / 8);
  localparam int MSB    = $clog2(AHB_DATA_WIDTH / 8) - 1;
  localparam int NLANES = AHB_DATA_WIDTH / CLIENT_DATA_WIDTH;

  typedef enum logic [1:0] {
    OK,
    ERR1,
    ERR2
  } err_state_e;

  logic                      valid_q;
  logic                      perr_q;
  logic                      write_q;
  logic [AHB_ADDR_WIDTH-1:0] addr_q;
  err_state_e                state_q;

  logic       accept;
  logic       perr_d;
  logic [6:0] align_mask;
  logic       err_state;
  logic       client_err;
  logic       err_first;
  int         lane_idx;

  // htrans_i[0] only separates NONSEQ from SEQ, which this block treats alike.
  logic       unused_htrans0;
  assign unused_htrans0 = htrans_i[0];

  assign accept = hsel_i & hready_i & htrans_i[1];

  // A transfer is rejected if it is wider than the client word or if the
  // address is not aligned to its own size. Sizes up to 7 fit in a 7-bit mask.
  assign align_mask = (7'd1 << hsize_i) - 7'd1;
  assign perr_d     = (hsize_i > 3'(LSB)) | (|(haddr_i[6:0] & align_mask));

  assign err_state  = (state_q != OK);
  assign dv         = valid_q & ~perr_q & ~err_state;

  // A client error counts only once the client stops stalling.
  assign client_err = dv & err & ~hld;

  // First ERROR cycle: either a registered protocol error (ERR1) or a client
  // error detected combinationally in this data phase.
  assign err_first   = (state_q == ERR1) | client_err;
  assign hreadyout_o = ~(dv & hld) & ~err_first;
  assign hresp_o     = err_first | (state_q == ERR2);

  assign write = write_q;
  assign addr  = addr_q;

  // Lane index comes from the registered address. When the client word is as
  // wide as the bus there is only one lane and no address bits to decode.
  generate
    if (MSB >= LSB) begin : g_lane
      assign lane_idx = int'(addr_q[MSB:LSB]);
    end else begin : g_single_lane
      assign lane_idx = 0;
    end
  endgenerate

  // Address-phase capture. The bus moves on only when hready_i is high.
  // While a transfer is stalled or in its first ERROR cycle, the captured
  // request is held stable.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (hready_i) begin
      valid_q <= accept;
      if (accept) begin
        addr_q  <= haddr_i;
        write_q <= hwrite_i;
        perr_q  <= perr_d;
      end
    end
  end

  // Error response sequencer. A protocol error is known at address time, so
  // its data phase starts directly in ERR1. A client error is only seen during
  // the data phase: that cycle is the first ERROR cycle, then ERR2 follows.
  // A new address phase may be accepted during ERR2 because hreadyout_o is
  // high there. A bad new transfer goes straight back to ERR1.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= OK;
    end else begin
      case (state_q)
        OK: begin
          if (accept & perr_d)  state_q <= ERR1;
          else if (client_err)  state_q <= ERR2;
        end
        ERR1:    state_q <= ERR2;
        ERR2:    state_q <= (accept & perr_d) ? ERR1 : OK;
        default: state_q <= OK;
      endcase
    end
  end

  // Write lane extraction from the AHB data bus.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_idx == i) wdata = hwdata_i[i*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH];
    end
  end

  // Read data: the client word is placed in its lane only during an active
  // read. All other lanes, and all idle cycles, read as zero.
  always_comb begin
    hrdata_o = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (dv && !write_q && lane_idx == i)
        hrdata_o[i*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH] = rdata;
    end
  end

endmodule

// File: tb/tb_ahb_lite_slv_sif.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_slv_sif
//
// Directed bench for ahb_lite_slv_sif with a 32-bit address, a 64-bit AHB
// data bus and a 32-bit client word. hready_i is looped back from
// hreadyout_o, as a single-subordinate fabric would do. Inputs change 1 time
// unit after the rising edge. Outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_lite_slv_sif;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        hclk;
  logic        hreset_n;
  logic [31:0] haddr_i;
  logic [2:0]  hsize_i;
  logic [1:0]  htrans_i;
  logic        hwrite_i;
  logic [63:0] hwdata_i;
  logic        hsel_i;
  logic        hready_i;
  logic [63:0] hrdata_o;
  logic        hreadyout_o;
  logic        hresp_o;
  logic        dv;
  logic        hld;
  logic        err;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic [31:0] rdata;

  int vector_count = 0;
  int miss_count   = 0;

  ahb_lite_slv_sif #(
    .AHB_ADDR_WIDTH   (32),
    .AHB_DATA_WIDTH   (64),
    .CLIENT_DATA_WIDTH(32)
  ) dut (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .haddr_i    (haddr_i),
    .hsize_i    (hsize_i),
    .htrans_i   (htrans_i),
    .hwrite_i   (hwrite_i),
    .hwdata_i   (hwdata_i),
    .hsel_i     (hsel_i),
    .hready_i   (hready_i),
    .hrdata_o   (hrdata_o),
    .hreadyout_o(hreadyout_o),
    .hresp_o    (hresp_o),
    .dv         (dv),
    .hld        (hld),
    .err        (err),
    .write      (write),
    .wdata      (wdata),
    .addr       (addr),
    .rdata      (rdata)
  );

  assign hready_i = hreadyout_o;

  // 10-unit clock period.
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Drives one AHB address-phase slot.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [31:0] a, input logic [2:0] size);
    hsel_i   = sel;
    htrans_i = trans;
    hwrite_i = wr;
    haddr_i  = a;
    hsize_i  = size;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, IDLE, 1'b0, 32'h0, 3'd0);
  endtask

  task automatic nextCycle();
    @(posedge hclk);
    #1;
  endtask

  // Single comparison point. Every check is counted, and every mismatch is reported.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    hreset_n = 1'b0;
    hld      = 1'b0;
    err      = 1'b0;
    rdata    = 32'h0;
    hwdata_i = 64'h0;
    idleBus();

    // Reset values.
    @(negedge hclk);
    checkOutput("rst_hreadyout", 64'(hreadyout_o), 64'd1);
    checkOutput("rst_hresp",     64'(hresp_o),     64'd0);
    checkOutput("rst_hrdata",    hrdata_o,         64'h0);
    checkOutput("rst_dv",        64'(dv),          64'd0);
    checkOutput("rst_addr",      64'(addr),        64'h0);
    checkOutput("rst_write",     64'(write),       64'd0);
    nextCycle();
    hreset_n = 1'b1;
    nextCycle();

    // Write 0xA5A5A5A5 at 0x104 with hsize 2. The upper lane is selected.
    applyStimulus(1'b1, NONSEQ, 1'b1, 32'h104, 3'd2);
    nextCycle();
    idleBus();
    hwdata_i = 64'hA5A5A5A5_5A5A5A5A;
    @(negedge hclk);
    checkOutput("wr_dv",        64'(dv),          64'd1);
    checkOutput("wr_write",     64'(write),       64'd1);
    checkOutput("wr_addr",      64'(addr),        64'h104);
    checkOutput("wr_wdata",     64'(wdata),       64'hA5A5A5A5);
    checkOutput("wr_hreadyout", 64'(hreadyout_o), 64'd1);
    checkOutput("wr_hresp",     64'(hresp_o),     64'd0);
    checkOutput("wr_hrdata",    hrdata_o,         64'h0);
    nextCycle();

    // Read at 0x008. The lower lane is selected.
    applyStimulus(1'b1, NONSEQ, 1'b0, 32'h008, 3'd2);
    nextCycle();
    idleBus();
    rdata = 32'h12345678;
    @(negedge hclk);
    checkOutput("rd8_hrdata",    hrdata_o,         64'h00000000_12345678);
    checkOutput("rd8_hreadyout", 64'(hreadyout_o), 64'd1);
    checkOutput("rd8_hresp",     64'(hresp_o),     64'd0);
    checkOutput("rd8_write",     64'(write),       64'd0);
    nextCycle();

    // Read at 0x00C. The upper lane is selected.
    applyStimulus(1'b1, NONSEQ, 1'b0, 32'h00C, 3'd2);
    nextCycle();
    idleBus();
    rdata = 32'hCAFEF00D;
    @(negedge hclk);
    checkOutput("rdC_hrdata", hrdata_o, 64'hCAFEF00D_00000000);
    nextCycle();

    // Read at 0x010 with hld high for 3 cycles.
    applyStimulus(1'b1, NONSEQ, 1'b0, 32'h010, 3'd2);
    nextCycle();
    idleBus();
    rdata = 32'h0BADBEEF;
    hld   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      checkOutput($sformatf("hld%0d_hreadyout", i), 64'(hreadyout_o), 64'd0);
      checkOutput($sformatf("hld%0d_dv", i),        64'(dv),          64'd1);
      checkOutput($sformatf("hld%0d_addr", i),      64'(addr),        64'h010);
      nextCycle();
    end
    hld = 1'b0;
    @(negedge hclk);
    checkOutput("hld3_dv",        64'(dv),          64'd1);
    checkOutput("hld3_hreadyout", 64'(hreadyout_o), 64'd1);
    checkOutput("hld3_hrdata",    hrdata_o,         64'h00000000_0BADBEEF);
    nextCycle();

    // Protocol errors: an oversized access, then a misaligned access.
    for (int t = 0; t < 2; t++) begin
      if (t == 0) applyStimulus(1'b1, NONSEQ, 1'b0, 32'h000, 3'd3);
      else        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h102, 3'd2);
      nextCycle();
      idleBus();
      @(negedge hclk);
      checkOutput($sformatf("perr%0d_c1_dv", t),        64'(dv),          64'd0);
      checkOutput($sformatf("perr%0d_c1_hresp", t),     64'(hresp_o),     64'd1);
      checkOutput($sformatf("perr%0d_c1_hreadyout", t), 64'(hreadyout_o), 64'd0);
      nextCycle();
      @(negedge hclk);
      checkOutput($sformatf("perr%0d_c2_dv", t),        64'(dv),          64'd0);
      checkOutput($sformatf("perr%0d_c2_hresp", t),     64'(hresp_o),     64'd1);
      checkOutput($sformatf("perr%0d_c2_hreadyout", t), 64'(hreadyout_o), 64'd1);
      nextCycle();
      @(negedge hclk);
      checkOutput($sformatf("perr%0d_c3_hresp", t),     64'(hresp_o),     64'd0);
      nextCycle();
    end

    // Client error on a write. A NONSEQ read is offered in the ERR2 cycle.
    applyStimulus(1'b1, NONSEQ, 1'b1, 32'h020, 3'd2);
    nextCycle();
    idleBus();
    err = 1'b1;
    @(negedge hclk);
    checkOutput("cerr_c1_dv",        64'(dv),          64'd1);
    checkOutput("cerr_c1_hresp",     64'(hresp_o),     64'd1);
    checkOutput("cerr_c1_hreadyout", 64'(hreadyout_o), 64'd0);
    nextCycle();
    err = 1'b0;
    applyStimulus(1'b1, NONSEQ, 1'b0, 32'h028, 3'd2);
    @(negedge hclk);
    checkOutput("cerr_c2_dv",        64'(dv),          64'd0);
    checkOutput("cerr_c2_hresp",     64'(hresp_o),     64'd1);
    checkOutput("cerr_c2_hreadyout", 64'(hreadyout_o), 64'd1);
    nextCycle();
    idleBus();
    rdata = 32'h55AA55AA;
    @(negedge hclk);
    checkOutput("cerr_nxt_dv",        64'(dv),          64'd1);
    checkOutput("cerr_nxt_addr",      64'(addr),        64'h028);
    checkOutput("cerr_nxt_hresp",     64'(hresp_o),     64'd0);
    checkOutput("cerr_nxt_hreadyout", 64'(hreadyout_o), 64'd1);
    checkOutput("cerr_nxt_hrdata",    hrdata_o,         64'h00000000_55AA55AA);
    nextCycle();

    // A client error raised while hld is high takes effect only after hld drops.
    applyStimulus(1'b1, NONSEQ, 1'b1, 32'h030, 3'd2);
    nextCycle();
    idleBus();
    hld = 1'b1;
    err = 1'b1;
    @(negedge hclk);
    checkOutput("herr_stall_hresp",     64'(hresp_o),     64'd0);
    checkOutput("herr_stall_hreadyout", 64'(hreadyout_o), 64'd0);
    nextCycle();
    hld = 1'b0;
    @(negedge hclk);
    checkOutput("herr_c1_hresp",     64'(hresp_o),     64'd1);
    checkOutput("herr_c1_hreadyout", 64'(hreadyout_o), 64'd0);
    nextCycle();
    err = 1'b0;
    @(negedge hclk);
    checkOutput("herr_c2_hresp",     64'(hresp_o),     64'd1);
    checkOutput("herr_c2_hreadyout", 64'(hreadyout_o), 64'd1);
    nextCycle();

    // BUSY, IDLE and unselected NONSEQ cycles complete with no request.
    applyStimulus(1'b1, BUSY, 1'b1, 32'h040, 3'd2);
    nextCycle();
    applyStimulus(1'b1, IDLE, 1'b1, 32'h044, 3'd2);
    @(negedge hclk);
    checkOutput("busy_dv",        64'(dv),          64'd0);
    checkOutput("busy_hreadyout", 64'(hreadyout_o), 64'd1);
    checkOutput("busy_hresp",     64'(hresp_o),     64'd0);
    nextCycle();
    applyStimulus(1'b0, NONSEQ, 1'b1, 32'h048, 3'd2);
    @(negedge hclk);
    checkOutput("idle_dv",        64'(dv),          64'd0);
    checkOutput("idle_hreadyout", 64'(hreadyout_o), 64'd1);
    nextCycle();
    idleBus();
    @(negedge hclk);
    checkOutput("nosel_dv",    64'(dv),      64'd0);
    checkOutput("nosel_hresp", 64'(hresp_o), 64'd0);
    nextCycle();

    // Reset asserted in the middle of a stalled read.
    applyStimulus(1'b1, NONSEQ, 1'b0, 32'h050, 3'd2);
    nextCycle();
    idleBus();
    hld = 1'b1;
    @(negedge hclk);
    checkOutput("rstmid_pre_hreadyout", 64'(hreadyout_o), 64'd0);
    #2;
    hreset_n = 1'b0;
    #1;
    checkOutput("rstmid_hreadyout", 64'(hreadyout_o), 64'd1);
    checkOutput("rstmid_dv",        64'(dv),          64'd0);
    checkOutput("rstmid_addr",      64'(addr),        64'h0);
    checkOutput("rstmid_hrdata",    hrdata_o,         64'h0);
    nextCycle();
    hld      = 1'b0;
    hreset_n = 1'b1;
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
